// File: rtl/ds18b20_pkg.sv
// Shared constants, FSM encoding and record helpers for the DS18B20 ASCII formatter.
package ds18b20_pkg;

   // ASCII characters used in the record
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   // Record geometry and conversion limits
   localparam int          REC_LEN     = 11;
   localparam int          CONV_CYCLES = 14;
   localparam int          BCD_IN_W    = CONV_CYCLES;   // one input bit shifted per cycle
   localparam logic [11:0] INT_SAT     = 12'd999;
   localparam logic [13:0] FRAC_SAT    = 14'd9375;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;

   // Everything needed to render one record
   typedef struct packed {
      logic        sign;
      logic [15:0] int_bcd;    // 4 BCD digits of the integer part
      logic [15:0] frac_bcd;   // 4 BCD digits of the fraction (x 1/10000)
   } rec_fields_t;

   // Fraction nibble (1/16 steps) to ten-thousandths
   function automatic logic [13:0] frac_scale(input logic [3:0] nib);
      return 14'(nib) * 14'd625;
   endfunction

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return ASCII_ZERO + {4'b0000, d};
   endfunction

   // Byte idx of the record. A non-zero thousands digit in the integer
   // part means the magnitude is over 999 and the integer field clamps.
   function automatic logic [7:0] rec_byte(input logic [3:0] idx, input rec_fields_t f);
      logic       int_sat;
      logic [7:0] b;
      int_sat = (f.int_bcd[15:12] != 4'd0);
      b       = 8'h00;
      case (idx)
         4'd0:    b = f.sign ? ASCII_MINUS : ASCII_PLUS;
         4'd1:    b = int_sat ? digit_char(4'd9) : digit_char(f.int_bcd[11:8]);
         4'd2:    b = int_sat ? digit_char(4'd9) : digit_char(f.int_bcd[7:4]);
         4'd3:    b = int_sat ? digit_char(4'd9) : digit_char(f.int_bcd[3:0]);
         4'd4:    b = ASCII_DOT;
         4'd5:    b = digit_char(f.frac_bcd[15:12]);
         4'd6:    b = digit_char(f.frac_bcd[11:8]);
         4'd7:    b = digit_char(f.frac_bcd[7:4]);
         4'd8:    b = digit_char(f.frac_bcd[3:0]);
         4'd9:    b = ASCII_CR;
         4'd10:   b = ASCII_LF;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// start loads bin_in; done is high during the cycle in which the final
// shift happens, so bcd_out holds the full result from the next cycle on.
module bin2bcd_seq
   import ds18b20_pkg::*;
(
   input  logic                clk_main,
   input  logic                reset,
   input  logic                start,
   input  logic [BCD_IN_W-1:0] bin_in,
   output logic [15:0]         bcd_out,
   output logic                done
);

   logic [BCD_IN_W-1:0] bin_sh;
   logic [3:0]          bit_cnt;
   logic [11:0]         bcd_adj;

   // Add-3 correction on the three low digits; the thousands digit never
   // shifts into a fifth digit for inputs below 10000.
   always_comb begin
      bcd_adj = bcd_out[11:0];
      for (int i = 0; i < 3; i++) begin
         if (bcd_out[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_out[4*i +: 4] + 4'd3;
      end
   end

   // Load on start, then shift one binary bit into the BCD register per cycle
   always_ff @(posedge clk_main or negedge reset) begin
      if (!reset) begin
         bin_sh  <= '0;
         bcd_out <= '0;
         bit_cnt <= '0;
      end else if (start) begin
         bin_sh  <= bin_in;
         bcd_out <= '0;
         bit_cnt <= 4'(BCD_IN_W);
      end else if (bit_cnt != 4'd0) begin
         bcd_out <= {bcd_out[14:12], bcd_adj, bin_sh[BCD_IN_W-1]};
         bin_sh  <= {bin_sh[BCD_IN_W-2:0], 1'b0};
         bit_cnt <= bit_cnt - 4'd1;
      end
   end

   assign done = (bit_cnt == 4'd1);

endmodule

// File: rtl/ds18b20_ascii_fmt.sv
// DS18B20 temperature word to 11-byte ASCII record ("+025.0625\r\n"),
// streamed one byte at a time to the UART transmitter. One sample can be
// held pending while a record is in flight; the newest pending sample wins.
//
// Handshake: tx_valid/tx_data are registered. A byte moves on a rising edge
// with tx_valid && tx_ready; the next byte appears the following cycle.
// While tx_valid && !tx_ready, tx_data is held and tx_valid stays high.
module ds18b20_ascii_fmt
   import ds18b20_pkg::*;
(
   input  logic        clk_main,
   input  logic        reset,
   input  logic [15:0] temp_raw,
   input  logic        temp_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   localparam logic [3:0] LAST_IDX = 4'(REC_LEN - 1);

   logic [1:0]          state;
   logic [1:0]          state_next;
   logic [3:0]          byte_idx;
   logic                sign_r;
   logic [15:0]         pend_data;
   logic                pend_flag;
   logic                start_conv;
   logic [15:0]         conv_src;
   logic [15:0]         mag;
   logic                int_over;
   logic [BCD_IN_W-1:0] int_in;
   logic [BCD_IN_W-1:0] frac_in;
   logic [15:0]         int_bcd;
   logic [15:0]         frac_bcd;
   logic                int_done;
   logic                frac_done;
   logic                conv_done;
   logic                last_accept;
   rec_fields_t         rec;

   assign last_accept = (state == ST_SEND) && tx_valid && tx_ready && (byte_idx == LAST_IDX);
   assign conv_done   = int_done && frac_done;
   assign rec         = {sign_r, int_bcd, frac_bcd};
   assign state_dbg   = state;

   // Pick when a conversion starts and which sample feeds it: a strobe in
   // IDLE, or at the end of a record a same-cycle strobe over the pending one.
   always_comb begin
      start_conv = 1'b0;
      conv_src   = temp_raw;
      if (state == ST_IDLE) begin
         start_conv = temp_valid;
      end else if (last_accept) begin
         start_conv = temp_valid | pend_flag;
         conv_src   = temp_valid ? temp_raw : pend_data;
      end
   end

   // Sign/magnitude split and saturation of the fraction for out-of-range values
   always_comb begin
      mag      = conv_src[15] ? (~conv_src + 16'd1) : conv_src;
      int_over = (mag[15:4] > INT_SAT);
      int_in   = {2'b00, mag[15:4]};
      frac_in  = int_over ? FRAC_SAT : frac_scale(mag[3:0]);
   end

   bin2bcd_seq u_int_bcd (
      .clk_main (clk_main),
      .reset    (reset),
      .start    (start_conv),
      .bin_in   (int_in),
      .bcd_out  (int_bcd),
      .done     (int_done)
   );

   bin2bcd_seq u_frac_bcd (
      .clk_main (clk_main),
      .reset    (reset),
      .start    (start_conv),
      .bin_in   (frac_in),
      .bcd_out  (frac_bcd),
      .done     (frac_done)
   );

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (temp_valid) state_next = ST_CONV;
         ST_CONV: if (conv_done)  state_next = ST_SEND;
         ST_SEND: if (last_accept) state_next = start_conv ? ST_CONV : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State, busy flag, latched sign and the registered byte stream
   always_ff @(posedge clk_main or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         sign_r   <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         byte_idx <= 4'd0;
      end else begin
         state <= state_next;
         busy  <= (state_next != ST_IDLE);
         if (start_conv)
            sign_r <= conv_src[15];
         if ((state == ST_CONV) && conv_done) begin
            // Sign byte only needs sign_r; the digits settle on this same edge
            tx_valid <= 1'b1;
            tx_data  <= rec_byte(4'd0, rec);
            byte_idx <= 4'd0;
         end else if ((state == ST_SEND) && tx_valid && tx_ready) begin
            if (byte_idx == LAST_IDX) begin
               tx_valid <= 1'b0;
               tx_data  <= 8'h00;
               byte_idx <= 4'd0;
            end else begin
               byte_idx <= byte_idx + 4'd1;
               tx_data  <= rec_byte(byte_idx + 4'd1, rec);
            end
         end
      end
   end

   // One-deep pending sample: strobes while busy overwrite it, a start consumes it
   always_ff @(posedge clk_main or negedge reset) begin
      if (!reset) begin
         pend_flag <= 1'b0;
         pend_data <= 16'h0000;
      end else if (start_conv) begin
         pend_flag <= 1'b0;
      end else if (temp_valid) begin
         pend_flag <= 1'b1;
         pend_data <= temp_raw;
      end
   end

endmodule

// File: tb/tb_ds18b20_ascii_fmt.sv
// Self-checking bench for ds18b20_ascii_fmt: expected records come from an
// arithmetic model of the temperature format and are compared byte by byte.
module tb_ds18b20_ascii_fmt;

   logic        clk_main = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] temp_raw = 16'h0000;
   logic        temp_valid = 1'b0;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic [1:0]  state_dbg;

   int          n_checks = 0;
   int          n_fail = 0;
   int          rdy_pct = 100;
   logic [7:0]  exp_q[$];
   logic        held = 1'b0;
   logic [7:0]  held_data = 8'h00;

   // ---------------- clock / reset ----------------
   always #10 clk_main = ~clk_main;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   ds18b20_ascii_fmt dut (
      .clk_main   (clk_main),
      .reset      (reset),
      .temp_raw   (temp_raw),
      .temp_valid (temp_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void push_record(input logic [15:0] raw);
      int mag, ip, fr;
      mag = raw[15] ? (65536 - int'(raw)) : int'(raw);
      ip  = mag / 16;
      fr  = (mag % 16) * 625;
      if (ip > 999) begin
         ip = 999;
         fr = 9375;
      end
      exp_q.push_back(raw[15] ? 8'h2D : 8'h2B);
      exp_q.push_back(8'(48 + ip / 100));
      exp_q.push_back(8'(48 + (ip / 10) % 10));
      exp_q.push_back(8'(48 + ip % 10));
      exp_q.push_back(8'h2E);
      exp_q.push_back(8'(48 + fr / 1000));
      exp_q.push_back(8'(48 + (fr / 100) % 10));
      exp_q.push_back(8'(48 + (fr / 10) % 10));
      exp_q.push_back(8'(48 + fr % 10));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   // ---------------- drivers ----------------
   initial forever begin
      @(posedge clk_main);
      #1;
      tx_ready = ($urandom_range(1, 100) <= rdy_pct);
   end

   task automatic strobe(input logic [15:0] raw);
      @(posedge clk_main);
      #1;
      temp_raw   = raw;
      temp_valid = 1'b1;
      @(posedge clk_main);
      #1;
      temp_valid = 1'b0;
   endtask

   task automatic send_sample(input logic [15:0] raw);
      push_record(raw);
      strobe(raw);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!tx_valid && n < 200) begin
         @(negedge clk_main);
         n++;
      end
      check("wait_valid_timeout", 32'(tx_valid), 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 3000) begin
         @(negedge clk_main);
         n++;
      end
      check("drain_timeout", 32'(busy || exp_q.size() != 0), 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial forever begin
      logic [7:0] e;
      @(negedge clk_main);
      if (!reset) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("stall_valid_held", 32'(tx_valid), 1);
            check("stall_data_held", 32'(tx_data), 32'(held_data));
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
            end else begin
               e = exp_q.pop_front();
               check("record_byte", 32'(tx_data), 32'(e));
            end
         end
         held      = tx_valid && !tx_ready;
         held_data = tx_data;
      end
   end

   // ---------------- stimulus ----------------
   logic [15:0] dir_vals[8] = '{16'h0191, 16'hFC90, 16'h07D0, 16'h0000,
                                16'hFFF8, 16'h8000, 16'h7FFF, 16'hFFF1};

   initial begin
      int k;
      logic [15:0] r1, r2;

      // Reset state
      repeat (3) @(posedge clk_main);
      #1;
      check("reset_tx_valid", 32'(tx_valid), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_tx_data", 32'(tx_data), 0);
      reset = 1'b1;
      repeat (2) @(posedge clk_main);

      // Latency: first byte 15 cycles after strobe, idle at cycle 26
      rdy_pct = 100;
      push_record(16'h0191);
      @(posedge clk_main);
      #1;
      temp_raw   = 16'h0191;
      temp_valid = 1'b1;
      @(posedge clk_main);
      #1;
      temp_valid = 1'b0;
      k = 1;
      @(negedge clk_main);
      check("busy_in_conv", 32'(busy), 1);
      while (!tx_valid && k < 40) begin
         @(negedge clk_main);
         k++;
      end
      check("first_valid_latency", 32'(k), 15);
      repeat (10) @(negedge clk_main);
      check("busy_last_byte", 32'(busy), 1);
      @(negedge clk_main);
      check("busy_after_record", 32'(busy), 0);
      check("tx_valid_after_record", 32'(tx_valid), 0);
      wait_idle();

      // Directed values, ready held high
      foreach (dir_vals[i]) begin
         send_sample(dir_vals[i]);
         wait_idle();
      end

      // Back-pressure at 30% ready
      rdy_pct = 30;
      send_sample(16'h0191);
      wait_idle();

      // Randomized samples, random ready duty, sometimes a pending strobe
      for (int i = 0; i < 10; i++) begin
         rdy_pct = $urandom_range(20, 100);
         r1 = 16'($urandom);
         r2 = 16'($urandom);
         send_sample(r1);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 9)) @(posedge clk_main);
            send_sample(r2);
         end
         wait_idle();
      end

      // Newest pending sample wins
      rdy_pct = 100;
      send_sample(16'h0191);
      wait_valid();
      strobe(16'h0010);
      repeat (3) @(posedge clk_main);
      strobe(16'h0020);
      push_record(16'h0020);
      wait_idle();

      // Strobe in the same cycle as the last byte is accepted
      send_sample(16'h0191);
      wait_valid();
      repeat (9) @(posedge clk_main);
      push_record(16'h0340);
      strobe(16'h0340);
      @(negedge clk_main);
      check("busy_chain_from_last_byte", 32'(busy), 1);
      wait_idle();

      // Reset mid-record at byte 5, then a clean record
      send_sample(16'h0191);
      wait_valid();
      repeat (5) @(posedge clk_main);
      #1;
      reset = 1'b0;
      #1;
      check("midreset_tx_valid", 32'(tx_valid), 0);
      check("midreset_busy", 32'(busy), 0);
      check("midreset_tx_data", 32'(tx_data), 0);
      exp_q.delete();
      repeat (3) @(posedge clk_main);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk_main);
      send_sample(16'h0010);
      wait_idle();

      // Nothing extra may follow
      repeat (40) @(negedge clk_main);
      check("queue_empty", 32'(exp_q.size()), 0);
      check("final_idle", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
